// File: rtl/csa_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding,
// and the signed-overflow rule applied on the final nibble.
package csa_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  // Code 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Overflow means the operands share a sign and the result sign differs from it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/csa_serial_adder_csa.sv
// 4-bit carry-select slice: the low half ripples, and the high half is computed
// for both carry-in values and then selected by the low-half carry.
module CSA_block_timed
  import csa_serial_adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in
);

  localparam int LO_W = NIBBLE_W / 2;
  localparam int HI_W = NIBBLE_W - LO_W;

  logic [LO_W:0]   c_lo;
  logic [HI_W:0]   c_hi0;
  logic [HI_W:0]   c_hi1;
  logic [HI_W-1:0] s_hi0;
  logic [HI_W-1:0] s_hi1;

  assign c_lo[0]  = c_in;
  assign c_hi0[0] = 1'b0;
  assign c_hi1[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < LO_W; gi++) begin : g_lo
      assign sum[gi]      = a[gi] ^ b[gi] ^ c_lo[gi];
      assign c_lo[gi + 1] = (a[gi] & b[gi]) | (c_lo[gi] & (a[gi] ^ b[gi]));
    end
    for (gi = 0; gi < HI_W; gi++) begin : g_hi
      assign s_hi0[gi]     = a[LO_W + gi] ^ b[LO_W + gi] ^ c_hi0[gi];
      assign c_hi0[gi + 1] = (a[LO_W + gi] & b[LO_W + gi]) | (c_hi0[gi] & (a[LO_W + gi] ^ b[LO_W + gi]));
      assign s_hi1[gi]     = a[LO_W + gi] ^ b[LO_W + gi] ^ c_hi1[gi];
      assign c_hi1[gi + 1] = (a[LO_W + gi] & b[LO_W + gi]) | (c_hi1[gi] & (a[LO_W + gi] ^ b[LO_W + gi]));
    end
  endgenerate

  assign sum[NIBBLE_W-1:LO_W] = c_lo[LO_W] ? s_hi1 : s_hi0;
  assign c_out                = c_lo[LO_W] ? c_hi1[HI_W] : c_hi0[HI_W];

endmodule

// File: rtl/csa_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single 4-bit
// carry-select slice, LSB first, with the slice carry registered between cycles.
module csa_serial_adder
  import csa_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_c_out;

  CSA_block_timed u_slice (
    .sum   (slice_sum),
    .c_out (slice_c_out),
    .a     (a_sh_q[NIBBLE_W-1:0]),
    .b     (b_sh_q[NIBBLE_W-1:0]),
    .c_in  (cy_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cy_d    = c_in;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          sum_d   = '0;
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d  = {slice_sum, sum_q[WIDTH-1:NIBBLE_W]};
        a_sh_d = {{NIBBLE_W{1'b0}}, a_sh_q[WIDTH-1:NIBBLE_W]};
        b_sh_d = {{NIBBLE_W{1'b0}}, b_sh_q[WIDTH-1:NIBBLE_W]};
        cy_d   = slice_c_out;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Final flags are registered here so they are valid in the DONE cycle.
          cnt_d   = '0;
          c_out_d = slice_c_out;
          ovf_d   = signed_ovf(a_msb_q, b_msb_q, slice_sum[NIBBLE_W-1]);
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_csa_serial_adder.sv
// Directed-vector and random bench for the nibble-serial adder (WIDTH=16).
module tb_csa_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  csa_serial_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at edge+1 while idle; returns at edge+1 back in IDLE.
  task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int cyc;
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!done) check({tag, " busy_in_run"}, 32'(busy), 32'd1);
    end
    check({tag, " latency"}, 32'(cyc), 32'd4);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " c_out"}, 32'(c_out), 32'(ec));
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    $display("%s: a=%04h b=%04h cin=%0d -> sum=%04h c_out=%0d ovf=%0d (exp %04h %0d %0d)",
             tag, ta, tb_v, tc, sum, c_out, overflow, es, ec, eo);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc, rov;
    int          done_cnt, first_done, second_done;
    logic [15:0] s1, s2;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset c_out", 32'(c_out), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    // rst and start on the same edge: reset wins.
    start = 1'b1; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    check("rst_over_start busy", 32'(busy), 32'd0);
    $display("rst_over_start: busy=%0d", busy);
    @(posedge clk); #1;
    check("rst_over_start still_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov,
              $sformatf("vec%0d", i));
    end

    // start held for 12 cycles with changing operands: exactly two adds.
    done_cnt = 0; first_done = -1; second_done = -1; s1 = '0; s2 = '0;
    for (int i = 0; i < 12; i++) begin
      start = 1'b1;
      a = 16'h0101 * 16'(i + 1);
      b = 16'h1000 + 16'(i);
      c_in = 1'b0;
      @(posedge clk); #1;
      if (i == 5) check("held_start idle_gap", 32'(busy), 32'd0);
      if (i == 6) check("held_start second_accept", 32'(busy), 32'd1);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin first_done = i; s1 = sum; end
        if (done_cnt == 2) begin second_done = i; s2 = sum; end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("held_start done_count", 32'(done_cnt), 32'd2);
    check("held_start first_done", 32'(first_done), 32'd4);
    check("held_start gap", 32'(second_done - first_done), 32'd6);
    check("held_start sum1", 32'(s1), 32'h1101);
    check("held_start sum2", 32'(s2), 32'h170D);
    $display("held_start: dones=%0d at %0d,%0d sums=%04h,%04h", done_cnt, first_done, second_done, s1, s2);

    // Reset during the RUN cycle with cnt==2 aborts the add.
    a = 16'h1234; b = 16'h4321; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort c_out", 32'(c_out), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    $display("abort: busy=%0d sum=%04h dones_after=%0d", busy, sum, done_cnt);
    run_add(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      rov = (ra[15] == rb[15]) && (full[15] != ra[15]);
      run_add(ra, rb, rc, full[15:0], full[16], rov, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
